// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings, master FSM states, command record and alignment helper.
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Command record storage width; the master's ADDR_W/DATA_W must not exceed these.
  localparam int AHB_ADDR_W = 32;
  localparam int AHB_DATA_W = 32;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    ERR2   = 2'd1,
    CANCEL = 2'd2
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [AHB_ADDR_W-1:0] addr;
    logic [2:0]            size;
    logic [AHB_DATA_W-1:0] wdata;
  } cmd_t;

  function automatic logic is_aligned(input logic [1:0] addr_lo, input logic [2:0] size);
    case (size)
      HSIZE_BYTE: is_aligned = 1'b1;
      HSIZE_HALF: is_aligned = !addr_lo[0];
      HSIZE_WORD: is_aligned = (addr_lo == 2'b00);
      default:    is_aligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_lite_master.sv
// AHB-Lite single-beat initiator: valid/ready commands in, pipelined NONSEQ transfers out.
// Optional alignment check enabled by defining AHB_LITE_MASTER_ALIGN_CHK_EN.
module ahb_lite_master
  import ahb_lite_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] HADDR,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic [1:0]        HTRANS,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  state_t            state, state_n;
  cmd_t              ap;
  logic              ap_v, ap_mis, dp_v, dp_write, cancel;
  logic [DATA_W-1:0] dp_wdata;
  logic              err1, ap_adv, cmd_fire, mis_in;

`ifdef AHB_LITE_MASTER_ALIGN_CHK_EN
  assign mis_in = !is_aligned(cmd_addr[1:0], cmd_size);
`else
  assign mis_in = 1'b0;
`endif

  // First ERROR cycle: slave holds HREADY low with HRESP high.
  assign err1     = (state == RUN) && dp_v && !HREADY && HRESP;
  // A misaligned entry never reaches the bus; it leaves AP once DP has drained.
  assign ap_adv   = !ap_v || (ap_mis ? !dp_v : HREADY);
  assign cmd_ready = HRESETn && (state == RUN) && ap_adv;
  assign cmd_fire = cmd_valid && cmd_ready;

  assign HADDR  = ADDR_W'(ap.addr);
  assign HWRITE = ap.write;
  assign HSIZE  = ap.size;
  assign HTRANS = (ap_v && !ap_mis) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HWDATA = dp_v ? dp_wdata : '0;
  assign HBURST = HBURST_SINGLE;
  assign HPROT  = HPROT_VAL;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) state <= RUN;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      RUN:     if (err1) state_n = ERR2;
      ERR2:    if (HREADY) state_n = cancel ? CANCEL : RUN;
      CANCEL:  state_n = RUN;
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      ap        <= '0;
      ap_v      <= 1'b0;
      ap_mis    <= 1'b0;
      dp_v      <= 1'b0;
      dp_write  <= 1'b0;
      dp_wdata  <= '0;
      cancel    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      case (state)
        RUN: begin
          if (err1) begin
            // Kill the transfer in AP; a command accepted this same cycle is cancelled too.
            ap_v   <= 1'b0;
            cancel <= ap_v || cmd_fire;
          end else begin
            if (HREADY) begin
              dp_v     <= ap_v && !ap_mis;
              dp_write <= ap.write;
              dp_wdata <= DATA_W'(ap.wdata);
              if (dp_v) begin
                rsp_valid <= 1'b1;
                rsp_err   <= HRESP;
                if (!HRESP && !dp_write) rsp_rdata <= HRDATA;
              end
            end
            if (ap_v && ap_mis && !dp_v) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end
            if (cmd_fire) begin
              ap.write <= cmd_write;
              ap.addr  <= AHB_ADDR_W'(cmd_addr);
              ap.size  <= cmd_size;
              ap.wdata <= AHB_DATA_W'(cmd_wdata);
              ap_v     <= 1'b1;
              ap_mis   <= mis_in;
            end else if (ap_adv) begin
              ap_v <= 1'b0;
            end
          end
        end
        ERR2: begin
          if (HREADY) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            dp_v      <= 1'b0;
          end
        end
        CANCEL: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          cancel    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: reset, pipelined table traffic, waits, ERROR/cancel, mid-op reset.
module tb_ahb_lite_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic        HWRITE, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;

  ahb_lite_master dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HTRANS(HTRANS), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Slave read data is a fixed function of the data-phase address.
  logic [31:0] dpa = '0;
  assign HRDATA = dpa ^ 32'hC0DE0000;
  always @(posedge HCLK) begin
    cyc <= cyc + 1;
    if (HREADY) dpa <= HADDR;
  end

  // Bus / response monitor, sampled mid-cycle.
  logic [32:0] rsp_q[$];
  logic [31:0] a_q[$];
  int          c_q[$];
  logic [31:0] wd_q[$];
  logic        mon_dpw = 1'b0;
  always @(negedge HCLK) begin
    if (!HRESETn) mon_dpw <= 1'b0;
    else begin
      if (rsp_valid) rsp_q.push_back({rsp_err, rsp_rdata});
      if (HREADY) begin
        if (mon_dpw) wd_q.push_back(HWDATA);
        mon_dpw <= (HTRANS == 2'b10) && HWRITE;
        if (HTRANS == 2'b10) begin
          a_q.push_back(HADDR);
          c_q.push_back(cyc);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  // Present a command and return at +1 after the accepting edge (cmd_valid left high).
  task automatic send(input logic w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    logic ok;
    ok = 1'b0;
    cmd_write = w; cmd_addr = a; cmd_size = s; cmd_wdata = d; cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (cmd_ready) ok = 1'b1;
      step();
      if (ok) break;
    end
    check("send_accept", 32'(ok), 32'd1);
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [2:0]  s;
    logic [31:0] d;
    logic [31:0] er;
  } vec_t;
  vec_t tbl[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int wk;
    int waited;
    tbl[0] = '{1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 32'h0};
    tbl[1] = '{1'b0, 32'h00, 3'd2, 32'h0,        32'hC0DE0000};
    tbl[2] = '{1'b0, 32'h04, 3'd2, 32'h0,        32'hC0DE0004};
    tbl[3] = '{1'b0, 32'h08, 3'd2, 32'h0,        32'hC0DE0008};
    tbl[4] = '{1'b1, 32'h02, 3'd1, 32'h1234,     32'h0};
    tbl[5] = '{1'b0, 32'h03, 3'd0, 32'h0,        32'hC0DE0003};

    HRESETn = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0; cmd_wdata = '0;

    // Reset state
    step(); step(); step();
    check("rst_htrans", 32'(HTRANS), 32'h0);
    check("rst_haddr", HADDR, 32'h0);
    check("rst_hwrite", 32'(HWRITE), 32'h0);
    check("rst_hsize", 32'(HSIZE), 32'h0);
    check("rst_hwdata", HWDATA, 32'h0);
    check("rst_hburst", 32'(HBURST), 32'h0);
    check("rst_hprot", 32'(HPROT), 32'h3);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'h0);
    cmd_valid = 1'b0;
    HRESETn = 1'b1;
    step();

    // Single write, zero-wait: T+1 address, T+2 data, T+3 response
    send(1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
    cmd_valid = 1'b0;
    check("wr_t1_htrans", 32'(HTRANS), 32'h2);
    check("wr_t1_haddr", HADDR, 32'h10);
    check("wr_t1_hwrite", 32'(HWRITE), 32'h1);
    check("wr_t1_hsize", 32'(HSIZE), 32'h2);
    step();
    check("wr_t2_htrans", 32'(HTRANS), 32'h0);
    check("wr_t2_hwdata", HWDATA, 32'hDEADBEEF);
    check("wr_t2_rsp_valid", 32'(rsp_valid), 32'h0);
    step();
    check("wr_t3_rsp_valid", 32'(rsp_valid), 32'h1);
    check("wr_t3_rsp_err", 32'(rsp_err), 32'h0);
    check("wr_t3_rsp_rdata", rsp_rdata, 32'h0);
    check("wr_t3_hwdata", HWDATA, 32'h0);
    step();
    check("wr_t4_rsp_valid", 32'(rsp_valid), 32'h0);

    // Table: back-to-back commands with cmd_valid held
    rsp_q.delete(); a_q.delete(); c_q.delete(); wd_q.delete();
    for (int i = 0; i < 6; i++) send(tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].d);
    cmd_valid = 1'b0;
    waited = 0;
    while (rsp_q.size() < 6 && waited < 20) begin step(); waited++; end
    check("tbl_rsp_count", 32'(rsp_q.size()), 32'd6);
    if (rsp_q.size() >= 6 && a_q.size() >= 6) begin
      wk = 0;
      for (int i = 0; i < 6; i++) begin
        check("tbl_rsp_err", 32'(rsp_q[i][32]), 32'h0);
        check("tbl_rsp_rdata", rsp_q[i][31:0], tbl[i].er);
        check("tbl_haddr", a_q[i], tbl[i].a);
        if (i > 0) check("tbl_b2b_cycle", 32'(c_q[i] - c_q[0]), 32'(i));
        if (tbl[i].w) begin
          if (wk < wd_q.size()) check("tbl_hwdata", wd_q[wk], tbl[i].d);
          else check("tbl_hwdata_missing", 32'(wd_q.size()), 32'(wk + 1));
          wk++;
        end
      end
    end
    step();

    // Write with 3 wait states, next read held in AP
    send(1'b1, 32'h40, 3'd2, 32'h11111111);
    send(1'b0, 32'h44, 3'd2, 32'h0);
    cmd_valid = 1'b0;
    HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ws_hwdata", HWDATA, 32'h11111111);
      check("ws_haddr", HADDR, 32'h44);
      check("ws_htrans", 32'(HTRANS), 32'h2);
      check("ws_cmd_ready", 32'(cmd_ready), 32'h0);
      check("ws_rsp_valid", 32'(rsp_valid), 32'h0);
      step();
      if (i == 2) HREADY = 1'b1;
    end
    step();
    check("ws_wr_rsp_valid", 32'(rsp_valid), 32'h1);
    check("ws_wr_rsp_err", 32'(rsp_err), 32'h0);
    check("ws_htrans_idle", 32'(HTRANS), 32'h0);
    step();
    check("ws_rd_rsp_valid", 32'(rsp_valid), 32'h1);
    check("ws_rd_rsp_rdata", rsp_rdata, 32'hC0DE0044);
    step();
    check("ws_rsp_done", 32'(rsp_valid), 32'h0);

    // ERROR on read 0x20 with read 0x24 pending in AP
    a_q.delete();
    send(1'b0, 32'h20, 3'd2, 32'h0);
    send(1'b0, 32'h24, 3'd2, 32'h0);
    cmd_valid = 1'b0;
    HREADY = 1'b0; HRESP = 1'b1;
    #1;
    check("err1_cmd_ready", 32'(cmd_ready), 32'h0);
    step();
    HREADY = 1'b1; HRESP = 1'b1;
    #1;
    check("err2_htrans_idle", 32'(HTRANS), 32'h0);
    check("err2_cmd_ready", 32'(cmd_ready), 32'h0);
    step();
    HRESP = 1'b0;
    #1;
    check("err_rsp1_valid", 32'(rsp_valid), 32'h1);
    check("err_rsp1_err", 32'(rsp_err), 32'h1);
    check("err_rsp1_rdata", rsp_rdata, 32'h0);
    check("cancel_cmd_ready", 32'(cmd_ready), 32'h0);
    step();
    check("err_rsp2_valid", 32'(rsp_valid), 32'h1);
    check("err_rsp2_err", 32'(rsp_err), 32'h1);
    step();
    check("err_rsp_done", 32'(rsp_valid), 32'h0);
    wk = 0;
    foreach (a_q[i]) if (a_q[i] == 32'h24) wk++;
    check("err_0x24_never_driven", 32'(wk), 32'h0);

    // Reset for one cycle during a data phase
    send(1'b1, 32'h80, 3'd2, 32'hCAFEF00D);
    cmd_valid = 1'b0;
    step();
    check("mr_hwdata_pre", HWDATA, 32'hCAFEF00D);
    HRESETn = 1'b0;
    #1;
    check("mr_cmd_ready_low", 32'(cmd_ready), 32'h0);
    step();
    check("mr_htrans", 32'(HTRANS), 32'h0);
    check("mr_haddr", HADDR, 32'h0);
    check("mr_hwrite", 32'(HWRITE), 32'h0);
    check("mr_hwdata", HWDATA, 32'h0);
    check("mr_rsp_valid", 32'(rsp_valid), 32'h0);
    HRESETn = 1'b1;
    step();
    check("mr_no_rsp", 32'(rsp_valid), 32'h0);
    send(1'b0, 32'h4, 3'd2, 32'h0);
    cmd_valid = 1'b0;
    step(); step();
    check("mr_after_rsp_valid", 32'(rsp_valid), 32'h1);
    check("mr_after_rdata", rsp_rdata, 32'hC0DE0004);
    step();

`ifdef AHB_LITE_MASTER_ALIGN_CHK_EN
    // Misaligned word at 0x6 is answered with an error and never driven
    a_q.delete();
    send(1'b1, 32'h6, 3'd2, 32'h55);
    cmd_valid = 1'b0;
    check("al_htrans_idle", 32'(HTRANS), 32'h0);
    step();
    check("al_rsp_valid", 32'(rsp_valid), 32'h1);
    check("al_rsp_err", 32'(rsp_err), 32'h1);
    check("al_htrans_idle2", 32'(HTRANS), 32'h0);
    step();
    check("al_rsp_done", 32'(rsp_valid), 32'h0);
    check("al_no_bus", 32'(a_q.size()), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
